mm_uart_tx: RTL
===============

Name: mm_uart_tx

Overview:
- Memory-mapped UART transmitter on the processor store bus, alongside the memory-mapped registers; decodes the same we/data/addr write signals.
- A store to ADDR pushes data[7:0] into an internal FIFO.
- A bit-timer FSM drains the FIFO onto a serial tx pin, 8N1, LSB first.
- Status outputs feed the read-back mux and LED/debug logic.

Parameters:
- DATA_WIDTH, 32, bus data/address width.
- ADDR, 32'h90000010, TX data register address. A write here enqueues a byte.
- CLR_ADDR, 32'h90000014, control address. A write with data[0]=1 clears overflow.
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200). Must be >= 2.
- FIFO_DEPTH, 8, byte entries. Must be a power of 2 and >= 2.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset. Asserts immediately; deasserts synchronously in the system.
- we  in  1  bus write enable.
- data  in  DATA_WIDTH  bus write data; only [7:0] is used.
- addr  in  DATA_WIDTH  bus write address.
- tx  out  1  serial output; idles high.
- busy  out  1  high when FIFO is non-empty or a frame is in progress.
- full  out  1  FIFO count == FIFO_DEPTH.
- overflow  out  1  sticky flag: a write to ADDR was dropped because the FIFO was full.
- count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset==0), applied asynchronously:
  - tx=1, busy=0, full=0, overflow=0, count=0.
  - FIFO pointers = 0; FSM = IDLE; bit timer and bit index = 0.
  - Reset mid-frame aborts the frame, drives tx high immediately and discards FIFO contents.
- Push:
  - Condition: we && addr==ADDR && !full, with full taken from registered state.
  - At that edge, data[7:0] is written at the write pointer.
- Dropped push:
  - Condition: we && addr==ADDR && full.
  - The byte is dropped and overflow is set to 1 at that edge.
  - A same-cycle pop does not rescue the push.
- Overflow clear:
  - Condition: we && addr==CLR_ADDR && data[0].
  - overflow is cleared at that edge.
  - If a dropped push and a clear coincide, the set wins (they are mutually exclusive anyway, since addr is unique).
- Other addresses: ignored entirely.
- Pop: the FSM pops when leaving IDLE, or at the end of STOP with the FIFO non-empty. The head byte is loaded into the shift register.
- Occupancy:
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: tx=1. If count!=0, pop and go to START at that edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit. After bit 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if count!=0, pop and go directly to START (back-to-back frames, no extra idle cycle); else go to IDLE.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1 and resets to 0 on every state or bit transition.
  - Each bit period is exactly CLKS_PER_BIT cycles.
- Latency:
  - Write accepted at edge k into an empty FIFO with the FSM in IDLE: tx falls at edge k+1.
  - A full frame is 10*CLKS_PER_BIT cycles.
- Output registering: tx is registered (glitch-free). busy = (state!=IDLE) || (count!=0).
- Unused data bits [DATA_WIDTH-1:8] are ignored.

Decomposition:
- Shared package mm_uart_pkg holds:
  - FSM state encoding (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3).
  - Frame constants (DATA_BITS=8, STOP_BITS=1).
  - Default CLKS_PER_BIT.
- One sub-module: sync_fifo.
  - Parameterised width and depth.
  - Ports: push, pop, wdata, rdata, count, full, empty.
  - Async active-low reset, same as the top level.
- The top level holds the address decode, overflow flag, FSM, bit timer and shift register.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 in simulation):
- Reset mid-frame: write 8'hA5, release reset, assert reset after 13 cycles -> tx=1 immediately; count=0; busy=0; no further edges on tx.
- Single byte: write 32'h000000A5 to ADDR -> tx low at the next edge for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; busy drops after 40 cycles.
- Back-to-back: write 8'h55 then 8'h0F on consecutive cycles -> second start bit begins exactly 40 cycles after the first; no idle gap; count goes 1 -> 1 -> 0 correctly.
- Full/overflow: 6 writes in consecutive cycles while idle -> one byte is popped immediately, so count reaches 4 and full=1; the 6th write is dropped and overflow=1; after all frames, 5 bytes observed on tx.
- Clear: write 32'h1 to CLR_ADDR -> overflow=0 next edge. Write 32'h0 to CLR_ADDR -> no change. Write to 32'h90000000 -> count unchanged, tx idle.
- Wrap-around: push/drain 10 bytes (0x01..0x0A) in bursts of 3 -> bytes appear in order across pointer wrap.

Source files
------------

// File: rtl/mm_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mm_uart_pkg;

    // Transmit FSM encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // 8N1 frame shape
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // 50 MHz core clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/mm_uart_tx_fifo.sv
// Generic synchronous FIFO with occupancy count; read data is the current head.
// Latency: push visible in count after one edge; rdata is combinational from head.
// Backpressure: pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only slots between the pointers are ever read
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mm_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus stores enqueue bytes, an FSM serialises them LSB first.
// Latency: store into empty FIFO at edge k drives the start bit at edge k+1; one frame = 10*CLKS_PER_BIT.
// Backpressure: none on the bus; stores while full are dropped and flagged in sticky overflow.
module mm_uart_tx
    import mm_uart_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] ADDR         = 32'h9000_0010,
    parameter logic [DATA_WIDTH-1:0] CLR_ADDR     = 32'h9000_0014,
    parameter int                    CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int                    FIFO_DEPTH   = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          we,
    input  logic [DATA_WIDTH-1:0]         data,
    input  logic [DATA_WIDTH-1:0]         addr,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int TW = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

    uart_state_t          state;
    uart_state_t          state_nxt;
    logic [TW-1:0]        timer;
    logic [TW-1:0]        timer_nxt;
    logic [BW-1:0]        bit_idx;
    logic [BW-1:0]        bit_idx_nxt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_nxt;
    logic                 tx_nxt;

    logic                 wr_tx_reg;
    logic                 push;
    logic                 drop;
    logic                 clr;
    logic                 pop;
    logic                 empty;
    logic [DATA_BITS-1:0] head;
    logic                 unused_data_hi;

    // Only the low byte of a store carries payload
    assign unused_data_hi = ^data[DATA_WIDTH-1:DATA_BITS];

    // Address decode; full is the registered FIFO state, so a same-cycle pop cannot rescue a push
    assign wr_tx_reg = we && (addr == ADDR);
    assign push      = wr_tx_reg && !full;
    assign drop      = wr_tx_reg && full;
    assign clr       = we && (addr == CLR_ADDR) && data[0];

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (data[DATA_BITS-1:0]),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign busy = (state != IDLE) || (count != '0);

    // Sticky overflow: a dropped store sets it, a control write with bit 0 clears it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr) begin
            overflow <= 1'b0;
        end
    end

    // FSM, bit timer and shift register state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
            tx      <= tx_nxt;
        end
    end

    // Next-state logic; tx is registered from the next state so it changes on the same edge as the FSM
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer + 1'b1;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_nxt = head;
                    state_nxt = START;
                end
            end
            START: begin
                if (timer == BIT_LAST) begin
                    timer_nxt   = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (timer == BIT_LAST) begin
                    timer_nxt = '0;
                    shift_nxt = shift >> 1;
                    if (bit_idx == IDX_LAST) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (timer == STOP_LAST) begin
                    timer_nxt = '0;
                    // Chain straight into the next start bit when more data is queued
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_nxt = head;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                timer_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
        tx_nxt = (state_nxt == DATA) ? shift_nxt[0] : (state_nxt != START);
    end

endmodule
